arb_req_queue: RTL and testbench
================================

// Module: arb_req_queue
// PURPOSE
//  Per-requester input queues feeding the 4-way round-robin arbiter (upstream stage).
//  Each port buffers payload words in a small FIFO and holds req[i] high while its FIFO is non-empty.
//  On the arbiter's one-hot grant, the head word of the granted FIFO is popped into a single
//  registered output stage (valid/ready), tagged with the source port index.
// PARAMETERS
//  NREQ   4  number of requesters; must match arbiter width
//  DW     8  payload width, bits
//  DEPTH  4  entries per port FIFO; power of 2, >= 2
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         asynchronous, active-high reset
//  in_valid  in   NREQ      per-port write request
//  in_ready  out  NREQ      per-port FIFO not full
//  in_data   in   NREQ*DW   port i payload at [i*DW +: DW]
//  req       out  NREQ      to arbiter req; bit i = FIFO i non-empty
//  grant     in   NREQ      from arbiter grant; one-hot or zero, registered by arbiter
//  out_valid out  1         output register holds a word
//  out_ready in   1         downstream accepts word
//  out_data  out  DW        popped payload
//  out_port  out  clog2(NREQ)  index of source port
// BEHAVIOUR
//  - Reset (async, asserts immediately): all FIFOs empty (ptrs/counts = 0), req=0, out_valid=0,
//    out_data=0, out_port=0. All in_ready=1 from the first edge after reset release.
//    Reset mid-transfer discards all queued and output data.
//  - FIFO i: count 0..DEPTH (clog2(DEPTH)+1 bits); ptrs wrap modulo DEPTH.
//    in_ready[i] = (count_i != DEPTH); it depends on count only, with no pop bypass.
//    Push when in_valid[i] & in_ready[i]. in_data is ignored when no push happens.
//  - req[i] = (count_i != 0), combinational from count. It drops the cycle after the last word is popped.
//  - slot_free = !out_valid | out_ready.
//  - Pop on FIFO i when: grant[i] & (count_i != 0) & slot_free & grant is one-hot.
//    On pop: out_data <= head_i, out_port <= i, out_valid <= 1 on the next edge.
//    Latency: grant edge to out_valid is 1 cycle.
//  - If there is no pop and out_ready is high: out_valid <= 0.
//  - If out_valid is high and out_ready is low: out_data and out_port hold. A grant in that
//    cycle is ignored; the word stays queued and req stays high so the arbiter re-grants it.
//  - Grant to an empty FIFO is ignored, with no count change. This is the normal 1-cycle lag after
//    the last pop.
//  - Multi-hot grant: no pop at all that cycle.
//  - Push and pop on the same port in the same cycle: count unchanged. Both pointers advance.
//  - A push into an empty FIFO is not poppable in the same cycle. req rises on the next cycle.
//  - Same-cycle pushes on several ports are all accepted independently.
// CONFIGURATION
//  ARB_Q_ERR_EN defined:
//    - Adds output err (1 bit), sticky, cleared only by rst.
//    - err sets the cycle after either of these: a multi-hot grant, or grant[i] with count_i==0
//      while req[i] was also 0 in the previous cycle. The second case is a true spurious grant
//      and excludes the 1-cycle lag.
//  ARB_Q_ERR_EN undefined:
//    - No err port and no checking logic. Queue behaviour is otherwise identical.
// TESTING
//  1 rst=1 for 3 cycles mid-stream -> req=0, out_valid=0, in_ready=4'b1111 after release
//  2 push 0xA1 on port0; grant=4'b0001 next cycle, out_ready=1 -> out_valid=1, out_data=0xA1,
//    out_port=0; req[0]=0
//  3 push 4 words on port2 with no grant -> in_ready[2]=0 after 4th push;
//    5th push is dropped, and count stays 4
//  4 ports 1 and 3 loaded 2 words each, out_ready=1, grant alternates 0010/1000
//    -> out_port sequence 1,3,1,3 with data in FIFO order, then req=0
//  5 out_ready=0 with out_valid=1, grant=4'b0100 -> no pop, count_2 unchanged, out_data held;
//    raise out_ready and regrant -> word delivered
//  6 grant=4'b0011 with both ports non-empty -> no pop;
//    with ARB_Q_ERR_EN, err=1 the next cycle and stays 1 until rst

Source files
------------

// File: rtl/arb_req_queue.sv
// arb_req_queue: per-port FIFOs raising req to a round-robin arbiter; the granted head is popped into one output register.
// Optional sticky grant-error flag `err` when ARB_Q_ERR_EN is defined.
module arb_req_queue #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    in_valid,
    output logic [NREQ-1:0]    in_ready,
    input  logic [NREQ*DW-1:0] in_data,
    output logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    grant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [PW-1:0]      out_port
`ifdef ARB_Q_ERR_EN
    ,
    output logic               err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [NREQ][DEPTH];
    logic [CW-1:0] cnt_q [NREQ];
    logic [CW-1:0] cnt_d [NREQ];
    logic [AW-1:0] wr_q  [NREQ];
    logic [AW-1:0] wr_d  [NREQ];
    logic [AW-1:0] rd_q  [NREQ];
    logic [AW-1:0] rd_d  [NREQ];
    logic [NREQ-1:0] push, pop;
    logic one_hot, slot_free;
    logic out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] out_port_q, out_port_d;

    always_comb begin
        one_hot     = (grant != '0) && ((grant & (grant - NREQ'(1))) == '0);
        slot_free   = !out_valid_q || out_ready;
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        for (int i = 0; i < NREQ; i++) begin
            in_ready[i] = cnt_q[i] != CW'(DEPTH);
            req[i]      = cnt_q[i] != '0;
            push[i]     = in_valid[i] && in_ready[i];
            pop[i]      = grant[i] && req[i] && slot_free && one_hot;
            cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            wr_d[i]     = wr_q[i] + AW'(push[i]);
            rd_d[i]     = rd_q[i] + AW'(pop[i]);
            if (pop[i]) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[i][rd_q[i]];
                out_port_d  = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
                wr_q[i]  <= wr_d[i];
                rd_q[i]  <= rd_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
        end
    end

    // Payload storage needs no reset; counts alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (push[i]) mem_q[i][wr_q[i]] <= in_data[i*DW +: DW];
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

`ifdef ARB_Q_ERR_EN
    logic [NREQ-1:0] req_prev_q;
    logic err_q, err_d;

    // A grant to a port that was also idle last cycle is spurious; one cycle of lag after the last pop is expected.
    always_comb err_d = err_q || (grant != '0 && !one_hot) || (|(grant & ~req & ~req_prev_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q <= '0;
            err_q      <= 1'b0;
        end else begin
            req_prev_q <= req;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_arb_req_queue.sv
// tb_arb_req_queue: directed checks of arb_req_queue push/pop, backpressure, grant corner cases and reset.
module tb_arb_req_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
`ifdef ARB_Q_ERR_EN
    logic        err;
`endif
    int checks = 0;
    int failures = 0;

    arb_req_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .req(req), .grant(grant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_port(out_port)
`ifdef ARB_Q_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; grant = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("init_in_ready", 32'(in_ready), 32'hf);
        chk("init_out_data", 32'(out_data), 32'h0);

        // single word through port0
        in_valid = 4'b0001; in_data = 32'h0000_00a1;
        tick();
        in_valid = '0; in_data = 32'hffff_ffff;
        chk("t2_req_after_push", 32'(req), 32'h1);
        grant = 4'b0001;
        tick();
        grant = '0;
        chk("t2_out_valid", 32'(out_valid), 32'h1);
        chk("t2_out_data", 32'(out_data), 32'ha1);
        chk("t2_out_port", 32'(out_port), 32'h0);
        chk("t2_req_drop", 32'(req), 32'h0);
        tick();
        chk("t2_out_valid_clear", 32'(out_valid), 32'h0);

        // fill port2, fifth push dropped
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b0100; in_data = {8'h00, 8'hb0 + 8'(k == 4 ? 15 : k), 16'h0};
            tick();
        end
        in_valid = '0;
        chk("t3_in_ready_full", 32'(in_ready), 32'hb);
        chk("t3_req2", 32'(req), 32'h4);

        // backpressure on port2 head
        grant = 4'b0100;
        tick();
        chk("t5_first_data", 32'(out_data), 32'hb0);
        chk("t5_in_ready_after_pop", 32'(in_ready), 32'hf);
        out_ready = 1'b0;
        tick();
        chk("t5_hold_valid", 32'(out_valid), 32'h1);
        chk("t5_hold_data", 32'(out_data), 32'hb0);
        chk("t5_req_held", 32'(req), 32'h4);
        out_ready = 1'b1;
        tick();
        chk("t5_regrant_data", 32'(out_data), 32'hb1);
        chk("t5_regrant_port", 32'(out_port), 32'h2);
        tick();
        chk("t3_data2", 32'(out_data), 32'hb2);
        tick();
        chk("t3_data3", 32'(out_data), 32'hb3);
        chk("t3_drained_req", 32'(req), 32'h0);
        tick();
        grant = '0;
        chk("t3_lag_grant_ignored", 32'(out_valid), 32'h0);
        chk("t3_lag_data_held", 32'(out_data), 32'hb3);
`ifdef ARB_Q_ERR_EN
        chk("err_lag_clear", 32'(err), 32'h0);
`endif

        // ports 1 and 3 interleaved
        in_valid = 4'b1010; in_data = 32'hd0_00_c0_00;
        tick();
        in_data = 32'hd1_00_c1_00;
        tick();
        in_valid = '0;
        chk("t4_req", 32'(req), 32'ha);
        grant = 4'b0010; tick();
        chk("t4_p0", 32'(out_port), 32'h1); chk("t4_d0", 32'(out_data), 32'hc0);
        grant = 4'b1000; tick();
        chk("t4_p1", 32'(out_port), 32'h3); chk("t4_d1", 32'(out_data), 32'hd0);
        grant = 4'b0010; tick();
        chk("t4_p2", 32'(out_port), 32'h1); chk("t4_d2", 32'(out_data), 32'hc1);
        grant = 4'b1000; tick();
        chk("t4_p3", 32'(out_port), 32'h3); chk("t4_d3", 32'(out_data), 32'hd1);
        chk("t4_req_empty", 32'(req), 32'h0);
        grant = '0; tick();
        chk("t4_idle", 32'(out_valid), 32'h0);

        // multi-hot grant
        in_valid = 4'b0011; in_data = 32'h0000_e1e0;
        tick();
        in_valid = '0;
        grant = 4'b0011;
        tick();
        grant = '0;
        chk("t6_no_pop", 32'(out_valid), 32'h0);
        chk("t6_req_kept", 32'(req), 32'h3);
`ifdef ARB_Q_ERR_EN
        chk("t6_err_set", 32'(err), 32'h1);
        tick();
        chk("t6_err_sticky", 32'(err), 32'h1);
`endif
        grant = 4'b0010;
        tick();
        grant = '0;
        chk("t6_after_p1", 32'(out_data), 32'he1);

        // mid-stream async reset with queued and output data
        in_valid = 4'b0100; in_data = 32'h0055_0000;
        rst = 1'b1;
        #1;
        chk("t1_async_req", 32'(req), 32'h0);
        chk("t1_async_valid", 32'(out_valid), 32'h0);
        in_valid = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("t1_in_ready", 32'(in_ready), 32'hf);
        chk("t1_req", 32'(req), 32'h0);
        chk("t1_out_data", 32'(out_data), 32'h0);
        chk("t1_out_port", 32'(out_port), 32'h0);
`ifdef ARB_Q_ERR_EN
        chk("t1_err_clear", 32'(err), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
